input_debounce_sync: RTL

//   Input conditioning stage for the D flip-flop. Takes an asynchronous, bouncy raw level (button/switch),

---
 rtl/input_debounce_sync.sv | 126 ++++++++++++
 1 files changed

// File: rtl/input_debounce_sync.sv
`default_nettype none
// ============================================================================
// input_debounce_sync -- synchronizes and debounces a raw level, emits edge
// pulses. Optional DEBOUNCE_GLITCH_CNT_EN adds a saturating abort counter.
// Revision: 1.0
// ============================================================================
module input_debounce_sync #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 3,
   parameter int GLITCH_W      = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                raw_in,
   output logic                d_out,
   output logic                rise_pulse,
   output logic                fall_pulse,
`ifdef DEBOUNCE_GLITCH_CNT_EN
   output logic [GLITCH_W-1:0] glitch_cnt,
`endif
   output logic                busy
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_LOW    = 2'd0,
      ST_WAIT_H = 2'd1,
      ST_HIGH   = 2'd2,
      ST_WAIT_L = 2'd3
   } state_t;

   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   logic                   abort;

   assign s     = sync[SYNC_STAGES-1];
   assign abort = ((state == ST_WAIT_H) && !s) || ((state == ST_WAIT_L) && s);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync       <= '0;
         state      <= ST_LOW;
         cnt        <= '0;
         d_out      <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         busy       <= 1'b0;
      end else begin
         sync       <= {sync[SYNC_STAGES-2:0], raw_in};
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         case (state)
            ST_LOW: begin
               if (s) begin
                  state <= ST_WAIT_H;
                  cnt   <= CNT_ONE;
                  busy  <= 1'b1;
               end
            end
            ST_WAIT_H: begin
               if (!s) begin
                  state <= ST_LOW;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  state      <= ST_HIGH;
                  cnt        <= '0;
                  busy       <= 1'b0;
                  d_out      <= 1'b1;
                  rise_pulse <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            ST_HIGH: begin
               if (!s) begin
                  state <= ST_WAIT_L;
                  cnt   <= CNT_ONE;
                  busy  <= 1'b1;
               end
            end
            ST_WAIT_L: begin
               if (s) begin
                  state <= ST_HIGH;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  state      <= ST_LOW;
                  cnt        <= '0;
                  busy       <= 1'b0;
                  d_out      <= 1'b0;
                  fall_pulse <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               state <= ST_LOW;
               cnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef DEBOUNCE_GLITCH_CNT_EN
   // Saturates rather than wraps so a long burst of noise stays visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         glitch_cnt <= '0;
      end else if (abort && (glitch_cnt != {GLITCH_W{1'b1}})) begin
         glitch_cnt <= glitch_cnt + {{(GLITCH_W-1){1'b0}}, 1'b1};
      end
   end
`else
   logic abort_unused;
   assign abort_unused = abort;
`endif

endmodule
`default_nettype wire
